// File: rtl/lenet_pkg.sv
// Shared definitions for the LeNet image front end.
// Holds the pixel width, the frame size, the core address width and the
// loader control state encoding. Modules import this package.
package lenet_pkg;

    localparam int WD     = 8;
    localparam int NPIX   = 1024;
    localparam int ADDR_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GO,
        ST_RUN,
        ST_RESULT
    } state_t;

endpackage

// File: rtl/img_bank_ram.sv
// One image bank: NPIX x WD storage with one write port and one registered
// read port.
//
// Ports:
//   clk    - clock, all logic on posedge
//   rst_n  - synchronous active-low reset (clears the read register only)
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   re     - read enable; rdata updates on the next edge, otherwise holds
//   raddr  - read address; addresses at or beyond NPIX read back as 0
//   rdata  - registered read data
module img_bank_ram #(
    parameter int WD   = lenet_pkg::WD,
    parameter int NPIX = lenet_pkg::NPIX
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          we,
    input  logic [lenet_pkg::ADDR_W-1:0]  waddr,
    input  logic [WD-1:0]                 wdata,
    input  logic                          re,
    input  logic [lenet_pkg::ADDR_W-1:0]  raddr,
    output logic [WD-1:0]                 rdata
);

    logic [WD-1:0] mem [NPIX];

    // Storage is deliberately not reset; only the read register is.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= (int'(raddr) < NPIX) ? mem[raddr] : '0;
        end
    end

endmodule

// File: rtl/image_pingpong_loader.sv
// Ping-pong image loader in front of the LeNet core.
// Pixels stream into one bank while the core reads the other. When a bank
// is full the control FSM pulses go, waits for the core's ready pulse,
// captures the digit and holds it until the downstream accepts it; that
// handshake frees the bank and moves the read side to the other bank.
//
// Ports:
//   clk, rst_n   - clock and synchronous active-low reset
//   s_valid/s_ready/s_data - pixel stream in, raster order
//   go           - one-cycle start pulse to the core
//   cena_image   - core read enable (active-low)
//   aa_image     - core read address
//   conv1_image  - registered read data to the core
//   ready, digit - core done pulse and its result
//   res_valid/res_ready/res_digit/res_err - held result out
//   frame_cnt    - completed results, wraps at 2^16
module image_pingpong_loader #(
    parameter int WD   = lenet_pkg::WD,
    parameter int NPIX = lenet_pkg::NPIX
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [WD-1:0]                 s_data,
    output logic                          go,
    input  logic                          cena_image,
    input  logic [lenet_pkg::ADDR_W-1:0]  aa_image,
    output logic [WD-1:0]                 conv1_image,
    input  logic                          ready,
    input  logic [3:0]                    digit,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [3:0]                    res_digit,
    output logic                          res_err,
    output logic [15:0]                   frame_cnt
);

    import lenet_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] waddr;
    logic              wbank;
    logic              rbank;
    logic              rsel;
    logic [1:0]        full, full_nxt;
    logic              beat, last_beat, res_hs;
    logic [WD-1:0]     rdata0, rdata1;

    assign s_ready   = !full[wbank];
    assign beat      = s_valid && s_ready;
    assign last_beat = beat && (waddr == LAST_ADDR);
    assign res_valid = (state == ST_RESULT);
    assign res_hs    = res_valid && res_ready;

    // Only the bank currently owned by the core is read; rsel remembers
    // which one so the output holds correctly while cena_image is high,
    // even after rbank has moved on.
    img_bank_ram #(.WD(WD), .NPIX(NPIX)) u_bank0 (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (beat && !wbank),
        .waddr (waddr),
        .wdata (s_data),
        .re    (!cena_image && !rbank),
        .raddr (aa_image),
        .rdata (rdata0)
    );

    img_bank_ram #(.WD(WD), .NPIX(NPIX)) u_bank1 (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (beat && wbank),
        .waddr (waddr),
        .wdata (s_data),
        .re    (!cena_image && rbank),
        .raddr (aa_image),
        .rdata (rdata1)
    );

    assign conv1_image = rsel ? rdata1 : rdata0;

    // Set and clear can land in the same cycle; they always target
    // different banks, so both are applied independently.
    always_comb begin
        full_nxt = full;
        if (last_beat) begin
            full_nxt[wbank] = 1'b1;
        end
        if (res_hs) begin
            full_nxt[rbank] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            waddr <= '0;
            wbank <= 1'b0;
            full  <= '0;
        end else begin
            full <= full_nxt;
            if (beat) begin
                waddr <= last_beat ? '0 : waddr + ADDR_W'(1);
                if (last_beat) begin
                    wbank <= !wbank;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        go        = 1'b0;
        unique case (state)
            ST_IDLE:   if (full[rbank]) state_nxt = ST_GO;
            ST_GO: begin
                go        = 1'b1;
                state_nxt = ST_RUN;
            end
            ST_RUN:    if (ready) state_nxt = ST_RESULT;
            ST_RESULT: if (res_ready) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            rbank     <= 1'b0;
            rsel      <= 1'b0;
            res_digit <= '0;
            res_err   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (!cena_image) begin
                rsel <= rbank;
            end
            // ready is only meaningful while the core is running.
            if (state == ST_RUN && ready) begin
                res_digit <= digit;
                res_err   <= (digit > 4'd9);
            end
            if (res_hs) begin
                rbank     <= !rbank;
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    // The write side only completes a bank that is empty and the read side
    // only frees a bank that is full, so they can never hit the same bank.
    a_no_same_bank: assert property (@(posedge clk) disable iff (!rst_n)
        !(last_beat && res_hs && (wbank == rbank)));

endmodule

// File: tb/tb_image_pingpong_loader.sv
// Randomized bench for image_pingpong_loader. The reference model tracks
// frames as whole objects: frame k written since reset is the frame the
// core's k-th job reads, and results come out in the order digits were given.
module tb_image_pingpong_loader;

    localparam int P_WD   = 8;
    localparam int P_NPIX = 1024;

    logic              clk;
    logic              rst_n;
    logic              s_valid;
    logic              s_ready;
    logic [P_WD-1:0]   s_data;
    logic              go;
    logic              cena_image;
    logic [9:0]        aa_image;
    logic [P_WD-1:0]   conv1_image;
    logic              ready;
    logic [3:0]        digit;
    logic              res_valid;
    logic              res_ready;
    logic [3:0]        res_digit;
    logic              res_err;
    logic [15:0]       frame_cnt;

    image_pingpong_loader #(.WD(P_WD), .NPIX(P_NPIX)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .go          (go),
        .cena_image  (cena_image),
        .aa_image    (aa_image),
        .conv1_image (conv1_image),
        .ready       (ready),
        .digit       (digit),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_digit   (res_digit),
        .res_err     (res_err),
        .frame_cnt   (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model state
    logic [P_WD-1:0] fmem [8][P_NPIX];
    int              frames_written;
    int              go_cnt;
    int              res_cnt;
    logic [3:0]      exp_q [$];
    logic            prev_go;
    logic [3:0]      mon_d;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Result and go monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (go === 1'b1) begin
                check("go_width", prev_go, 0);
                check("go_order", go_cnt, res_cnt);
                check("go_frame", (go_cnt < frames_written), 1);
                go_cnt++;
            end
            if (res_valid === 1'b1 && res_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("res_unexp", 1, 0);
                end else begin
                    mon_d = exp_q.pop_front();
                    check("res_digit", res_digit, mon_d);
                    check("res_err", res_err, (mon_d > 4'd9));
                end
                check("frame_cnt", frame_cnt, res_cnt & 32'hFFFF);
                res_cnt++;
            end
        end
        prev_go = go;
    end

    task automatic fill_random(input int k);
        for (int i = 0; i < P_NPIX; i++) fmem[k % 8][i] = P_WD'($urandom);
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        s_valid    = 1'b0;
        cena_image = 1'b1;
        ready      = 1'b0;
        digit      = 4'd0;
        res_ready  = 1'b0;
        tick();
        tick();
        check("rst_go", go, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_digit", res_digit, 0);
        check("rst_res_err", res_err, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_conv1", conv1_image, 0);
        frames_written = 0;
        go_cnt         = 0;
        res_cnt        = 0;
        exp_q.delete();
        rst_n = 1'b1;
        #1;
        check("rst_s_ready", s_ready, 1);
    endtask

    // Streams the first nbeats pixels of model frame k.
    task automatic stream(input int k, input int nbeats, input bit gaps);
        int  stall;
        bit  done;
        for (int i = 0; i < nbeats; i++) begin
            stall = 0;
            done  = 1'b0;
            while (!done) begin
                if (gaps && $urandom_range(0, 3) == 0) begin
                    s_valid = 1'b0;
                    tick();
                end else begin
                    s_valid = 1'b1;
                    s_data  = fmem[k % 8][i];
                    done    = s_ready;
                    tick();
                end
                if (!done) begin
                    stall++;
                    if (stall > 6000) begin
                        check("stall_timeout", 1, 0);
                        s_valid = 1'b0;
                        return;
                    end
                end
            end
        end
        s_valid = 1'b0;
        if (nbeats == P_NPIX) frames_written++;
    endtask

    // Core model for job k: waits for go, reads a few pixels, returns d.
    task automatic core_job(input int k, input logic [3:0] d, input int nreads, input bit rd37);
        int         t;
        logic [9:0] a;
        t = 0;
        while (go !== 1'b1) begin
            tick();
            t++;
            if (t > 8000) begin
                check("go_timeout", 1, 0);
                return;
            end
        end
        tick();
        for (int r = 0; r < nreads; r++) begin
            if (rd37 && r == 0) a = 10'd37;
            else                a = 10'($urandom_range(0, P_NPIX - 1));
            cena_image = 1'b0;
            aa_image   = a;
            tick();
            if (rd37 && r == 0) check("rd37", conv1_image, fmem[k % 8][a]);
            else                check("rd_data", conv1_image, fmem[k % 8][a]);
        end
        cena_image = 1'b1;
        aa_image   = 10'($urandom);
        tick();
        check("rd_hold", conv1_image, fmem[k % 8][a]);
        repeat ($urandom_range(0, 4)) tick();
        ready = 1'b1;
        digit = d;
        exp_q.push_back(d);
        tick();
        ready = 1'b0;
        digit = 4'($urandom);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        rst_n      = 1'b0;
        s_valid    = 1'b0;
        s_data     = '0;
        cena_image = 1'b1;
        aa_image   = '0;
        ready      = 1'b0;
        digit      = '0;
        res_ready  = 1'b0;
        frames_written = 0;
        go_cnt     = 0;
        res_cnt    = 0;
        tick();

        // One frame, pixel i = i % 256
        do_reset();
        for (int i = 0; i < P_NPIX; i++) fmem[0][i] = P_WD'(i % 256);
        res_ready = 1'b1;
        fork
            stream(0, P_NPIX, 1'b0);
            core_job(0, 4'd5, 4, 1'b1);
        join
        repeat (10) tick();
        check("one_go_cnt", go_cnt, 1);
        check("one_frame_cnt", frame_cnt, 1);

        // Back-to-back, three frames, digits 3, 7, 9
        do_reset();
        for (int k = 0; k < 3; k++) fill_random(k);
        res_ready = 1'b1;
        fork
            begin
                stream(0, P_NPIX, 1'b0);
                stream(1, P_NPIX, 1'b0);
                stream(2, P_NPIX, 1'b0);
            end
            begin
                core_job(0, 4'd3, 3, 1'b0);
                core_job(1, 4'd7, 3, 1'b0);
                core_job(2, 4'd9, 3, 1'b0);
            end
        join
        repeat (10) tick();
        check("b2b_frame_cnt", frame_cnt, 3);
        check("b2b_pending", exp_q.size(), 0);

        // Backpressure: result held, both banks fill, writer stops
        do_reset();
        for (int k = 0; k < 3; k++) fill_random(k);
        res_ready = 1'b0;
        fork
            begin
                stream(0, P_NPIX, 1'b0);
                stream(1, P_NPIX, 1'b0);
            end
            core_job(0, 4'd1, 2, 1'b0);
        join
        check("bp_s_ready", s_ready, 0);
        repeat (20) tick();
        check("bp_no_go", go_cnt, 1);
        check("bp_res_valid", res_valid, 1);
        check("bp_s_ready_hold", s_ready, 0);
        fork
            begin
                repeat (3) tick();
                res_ready = 1'b1;
            end
            core_job(1, 4'd2, 2, 1'b0);
        join
        fork
            stream(2, P_NPIX, 1'b1);
            core_job(2, 4'd4, 2, 1'b0);
        join
        repeat (10) tick();
        check("bp_frame_cnt", frame_cnt, 3);

        // Error digit
        do_reset();
        fill_random(0);
        res_ready = 1'b0;
        fork
            stream(0, P_NPIX, 1'b1);
            core_job(0, 4'd12, 3, 1'b0);
        join
        check("err_valid", res_valid, 1);
        check("err_digit", res_digit, 12);
        check("err_flag", res_err, 1);
        res_ready = 1'b1;
        repeat (5) tick();
        check("err_frame_cnt", frame_cnt, 1);

        // Stray done in IDLE
        do_reset();
        res_ready = 1'b1;
        ready = 1'b1;
        digit = 4'd4;
        tick();
        ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check("stray_res_valid", res_valid, 0);
            tick();
        end
        check("stray_frame_cnt", frame_cnt, 0);

        // Reset mid-frame
        do_reset();
        fill_random(0);
        res_ready = 1'b1;
        stream(0, 500, 1'b0);
        cena_image = 1'b0;
        aa_image   = 10'd5;
        tick();
        do_reset();
        fill_random(0);
        res_ready = 1'b1;
        fork
            stream(0, P_NPIX, 1'b1);
            core_job(0, 4'd6, 3, 1'b0);
        join
        repeat (10) tick();
        check("mid_go_cnt", go_cnt, 1);
        check("mid_frame_cnt", frame_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
